instr_sequencer: RTL and testbench

Program-store and issue sequencer that sits directly upstream of `cpu_top`. It holds up to 256 11-bit instructions loaded through a write port. On `start` it issues them in order to the CPU's `instruction` input, holding each instruction for exactly the three CPU cycles (FETCH, EXEC, STORE). It controls the CPU reset so that no instruction executes outside a run, and it stops at the first unwritten slot or at the programmed length.

---
 rtl/instr_sequencer_pkg.sv | 19 +
 rtl/instr_sequencer_prog_mem.sv | 37 +++
 rtl/instr_sequencer.sv | 144 ++++++++++++++
 tb/tb_instr_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared encodings and sizes for the instruction sequencer and its program store.
package instr_sequencer_pkg;

    localparam int DEPTH      = 256;
    localparam int ADDR_W     = 8;
    localparam int INSTR_W    = 11;
    localparam int SEQ_PHASES = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_DONE = 2'd2
    } seq_state_e;

    function automatic logic last_phase(input logic [1:0] ph);
        return ph == 2'(SEQ_PHASES - 1);
    endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: instruction array with a per-slot valid vector.
// Data is never reset; only the valid bits are.
module seq_prog_mem
    import instr_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               clr,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data,
    output logic               rd_valid
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   valid;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // A write in the same cycle as clr wins for its own slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else begin
            if (clr)   valid <= '0;
            if (wr_en) valid[wr_addr] <= 1'b1;
        end
    end

    assign rd_data  = mem[rd_addr];
    assign rd_valid = valid[rd_addr];

endmodule

// File: rtl/instr_sequencer.sv
// Program-store and issue sequencer feeding cpu_top; holds each instruction for
// the three CPU phases and keeps the CPU in reset outside a run.
//
// state    | meaning
// SEQ_IDLE | after reset, program may be loaded
// SEQ_RUN  | issuing instructions, CPU out of reset
// SEQ_DONE | run finished, CPU held in reset, program may be reloaded
module instr_sequencer
    import instr_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               clr,
    input  logic [ADDR_W:0]    prog_len,
    input  logic               start,
    output logic [INSTR_W-1:0] instruction,
    output logic               cpu_rst_n,
    output logic [ADDR_W-1:0]  pc,
    output logic [1:0]         phase,
    output logic               retire,
    output logic               busy,
    output logic               done,
    output logic               wr_err,
    output logic [ADDR_W:0]    instr_count
);

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [1:0]         phase_q, phase_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               wr_err_q;

    logic               accept;
    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               rd_valid;
    logic               run_end;

    assign accept  = (state_q != SEQ_RUN) && !start;
    // In RUN the read port looks ahead to the next slot; otherwise at slot 0 for start.
    assign rd_addr = (state_q == SEQ_RUN) ? pc_q + 1'b1 : '0;

    seq_prog_mem u_mem (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en && accept),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr      (clr && accept),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    // pc == DEPTH-1 is tested before the look-ahead, whose address has wrapped.
    assign run_end = (({1'b0, pc_q} + 1'b1) == len_q)
                  || (pc_q == ADDR_W'(DEPTH - 1))
                  || !rd_valid;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        phase_d   = phase_q;
        instr_d   = instr_q;
        cpu_rst_d = cpu_rst_q;
        count_d   = count_q;
        len_d     = len_q;
        case (state_q)
            SEQ_IDLE, SEQ_DONE: begin
                if (start) begin
                    len_d   = prog_len;
                    count_d = '0;
                    pc_d    = '0;
                    phase_d = '0;
                    if (prog_len == '0 || !rd_valid) begin
                        state_d   = SEQ_DONE;
                        instr_d   = '0;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d   = SEQ_RUN;
                        instr_d   = rd_data;
                        cpu_rst_d = 1'b1;
                    end
                end
            end
            SEQ_RUN: begin
                if (last_phase(phase_q)) begin
                    count_d = count_q + 1'b1;
                    phase_d = '0;
                    if (run_end) begin
                        state_d   = SEQ_DONE;
                        instr_d   = '0;
                        cpu_rst_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + 1'b1;
                        instr_d = rd_data;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEQ_IDLE;
            pc_q      <= '0;
            phase_q   <= '0;
            instr_q   <= '0;
            cpu_rst_q <= 1'b0;
            count_q   <= '0;
            len_q     <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            phase_q   <= phase_d;
            instr_q   <= instr_d;
            cpu_rst_q <= cpu_rst_d;
            count_q   <= count_d;
            len_q     <= len_d;
            wr_err_q  <= (wr_en || clr) && !accept;
        end
    end

    assign instruction = instr_q;
    assign cpu_rst_n   = cpu_rst_q;
    assign pc          = pc_q;
    assign phase       = phase_q;
    assign retire      = (state_q == SEQ_RUN) && last_phase(phase_q);
    assign busy        = (state_q == SEQ_RUN);
    assign done        = (state_q == SEQ_DONE);
    assign wr_err      = wr_err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus pushes expected issues and run
// results computed from a slot/valid model; a negedge monitor pops and compares.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               wr_en = 1'b0;
    logic [ADDR_W-1:0]  wr_addr = '0;
    logic [INSTR_W-1:0] wr_data = '0;
    logic               clr = 1'b0;
    logic [ADDR_W:0]    prog_len = '0;
    logic               start = 1'b0;
    logic [INSTR_W-1:0] instruction;
    logic               cpu_rst_n;
    logic [ADDR_W-1:0]  pc;
    logic [1:0]         phase;
    logic               retire, busy, done, wr_err;
    logic [ADDR_W:0]    instr_count;

    instr_sequencer dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr(clr), .prog_len(prog_len), .start(start),
        .instruction(instruction), .cpu_rst_n(cpu_rst_n), .pc(pc), .phase(phase),
        .retire(retire), .busy(busy), .done(done), .wr_err(wr_err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct { int pc; int instr; } issue_t;
    typedef struct { int count; int pc; bit check_pc; } end_t;

    int     n_checks = 0;
    int     n_fail = 0;
    issue_t exp_q[$];
    end_t   end_q[$];
    int     err_pending = 0;
    logic [INSTR_W-1:0] m_mem [DEPTH];
    bit     m_valid [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: checks every cycle against the queued expectations.
    int ph_m = 0;
    bit done_q = 0, start_q = 0, retire_q = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            check("cpu_rst_n_vs_busy", cpu_rst_n, busy);
            check("wr_err", wr_err, err_pending > 0);
            if (err_pending > 0) err_pending--;
            if (busy) begin
                if (exp_q.size() == 0) begin
                    fail_now("issue_unexpected");
                end else begin
                    check("issue_instr", instruction, exp_q[0].instr);
                    check("issue_pc", pc, exp_q[0].pc);
                    check("issue_phase", phase, ph_m);
                    check("issue_retire", retire, ph_m == 2);
                    if (ph_m == 2) void'(exp_q.pop_front());
                end
                ph_m = (ph_m + 1) % 3;
            end else begin
                check("retire_idle", retire, 0);
                ph_m = 0;
            end
            if (done && (!done_q || start_q)) begin
                if (end_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    end_t e;
                    e = end_q.pop_front();
                    check("end_count", instr_count, e.count);
                    if (e.check_pc) check("end_pc", pc, e.pc);
                    check("end_instr_zero", instruction, 0);
                    check("end_phase_zero", phase, 0);
                    check("end_leftover", exp_q.size(), 0);
                    check("done_after_retire", retire_q, e.count > 0);
                end
            end
            done_q   = done;
            start_q  = start;
            retire_q = retire;
        end else begin
            ph_m = 0; done_q = 0; start_q = 0; retire_q = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = INSTR_W'(d);
        tick();
        wr_en = 1'b0;
        m_mem[a] = INSTR_W'(d);
        m_valid[a] = 1'b1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    // Reference: issue slots in order until the limit, the last slot, or a hole.
    task automatic do_start(input int len);
        int p;
        issue_t it;
        end_t e;
        p = 0;
        while (p < len && p < DEPTH && m_valid[p]) begin
            it.pc = p;
            it.instr = int'(m_mem[p]);
            exp_q.push_back(it);
            p++;
        end
        e.count = p;
        e.pc = (p > 0) ? p - 1 : 0;
        e.check_pc = (p > 0);
        end_q.push_back(e);
        prog_len = (ADDR_W + 1)'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, p > 0);
        check("start_done", done, p == 0);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        if (!done) fail_now("done_timeout");
        tick();
    endtask

    initial begin
        #12;
        check("rst_instruction", instruction, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_pc", pc, 0);
        check("rst_phase", phase, 0);
        check("rst_flags", {retire, busy, done, wr_err}, 0);
        check("rst_count", instr_count, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        // Basic three-instruction run.
        do_write(0, 'h101); do_write(1, 'h212); do_write(2, 'h323);
        do_start(3);
        wait_done(20);

        // Hole at slot 2.
        do_clr();
        do_write(0, 'h0AA); do_write(1, 'h155); do_write(3, 'h3C3);
        do_start(5);
        wait_done(30);

        // Empty program with slot 0 valid.
        do_start(0);
        wait_done(5);

        // Rejected write and clr during a run; rerun keeps the original slot 1.
        do_clr();
        do_write(0, 'h011); do_write(1, 'h022); do_write(2, 'h033); do_write(3, 'h044);
        do_start(4);
        tick();
        wr_en = 1'b1; wr_addr = 8'd1; wr_data = 11'h7FF;
        tick();
        wr_en = 1'b0; err_pending++;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0; err_pending++;
        wait_done(40);
        do_start(4);
        wait_done(40);

        // clr and write in the same cycle: the written slot survives.
        clr = 1'b1; wr_en = 1'b1; wr_addr = 8'd0; wr_data = 11'h4D2;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_mem[0] = 11'h4D2; m_valid[0] = 1'b1;
        do_start(4);
        wait_done(20);

        // Randomized small programs.
        for (int it = 0; it < 8; it++) begin
            do_clr();
            for (int w = 0; w < int'($urandom_range(0, 14)); w++)
                do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 2047)));
            do_start(int'($urandom_range(0, 17)));
            wait_done(200);
        end

        // Full program.
        do_clr();
        for (int a = 0; a < DEPTH; a++) do_write(a, int'($urandom_range(0, 2047)));
        do_start(256);
        wait_done(800);

        // Reset during phase 1 of pc 1.
        do_clr();
        for (int a = 0; a < 4; a++) do_write(a, 'h100 + a);
        do_start(4);
        begin
            int k;
            k = 0;
            while (!(busy && pc == 8'd1 && phase == 2'd1) && k < 20) begin
                tick();
                k++;
            end
            if (k >= 20) fail_now("reach_pc1_phase1");
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_instruction", instruction, 0);
        check("mid_rst_cpu_rst_n", cpu_rst_n, 0);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_flags", {retire, busy, done, wr_err}, 0);
        check("mid_rst_count", instr_count, 0);
        exp_q.delete();
        end_q.delete();
        err_pending = 0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        do_start(4);
        wait_done(5);

        check("err_pending_final", err_pending, 0);
        check("end_q_final", end_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
